async_fifo_controller: RTL and testbench

//   Single-clock FIFO buffer controller with registered read data and a read-valid strobe.

---
 rtl/async_fifo_controller.sv | 74 +++++++
 tb/tb_async_fifo_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_controller.sv
// Single-clock FIFO controller with registered read data, a read-valid strobe and
// registered empty/full flags. Reset is asynchronous and active-high.
module async_fifo_controller #(
  parameter int pFifoDepth    = 1024,
  parameter int pFifoBitWidth = 4
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [pFifoBitWidth-1:0] iWd,
  input  logic                     iWe,
  output logic                     oFull,
  input  logic                     iRe,
  output logic [pFifoBitWidth-1:0] oRd,
  output logic                     oRvd,
  output logic                     oEmp
);

  localparam int AW = $clog2(pFifoDepth);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [pFifoBitWidth-1:0] r_mem [pFifoDepth];
  logic [AW:0]              r_wptr;
  logic [AW:0]              r_rptr;
  logic                     r_full;
  logic                     r_emp;
  logic                     r_rvd;
  logic [pFifoBitWidth-1:0] r_rd;

  logic                     w_wrAccept;
  logic                     w_rdAccept;
  logic [AW:0]              w_wptrNext;
  logic [AW:0]              w_rptrNext;

  // Each side is qualified only by its own request and its own flag.
  assign w_wrAccept = iWe && !r_full;
  assign w_rdAccept = iRe && !r_emp;

  always_comb begin
    w_wptrNext = r_wptr;
    w_rptrNext = r_rptr;
    if (w_wrAccept) w_wptrNext = r_wptr + PTR_ONE;
    if (w_rdAccept) w_rptrNext = r_rptr + PTR_ONE;
  end

  always_ff @(posedge iCLK) begin
    if (w_wrAccept) r_mem[r_wptr[AW-1:0]] <= iWd;
  end

  // Flags come from the next-state pointers so they are exact right after any access.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_emp  <= 1'b1;
      r_full <= 1'b0;
      r_rvd  <= 1'b0;
      r_rd   <= '0;
    end else begin
      r_wptr <= w_wptrNext;
      r_rptr <= w_rptrNext;
      r_emp  <= (w_wptrNext == w_rptrNext);
      r_full <= (w_wptrNext[AW-1:0] == w_rptrNext[AW-1:0]) &&
                (w_wptrNext[AW] != w_rptrNext[AW]);
      r_rvd  <= w_rdAccept;
      if (w_rdAccept) r_rd <= r_mem[r_rptr[AW-1:0]];
    end
  end

  assign oFull = r_full;
  assign oEmp  = r_emp;
  assign oRvd  = r_rvd;
  assign oRd   = r_rd;

endmodule

// File: tb/tb_async_fifo_controller.sv
// Self-checking bench for async_fifo_controller: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_async_fifo_controller;

  localparam int DEPTH = 1024;
  localparam int W     = 4;

  logic         iCLK = 1'b0;
  logic         iRST = 1'b0;
  logic         iWe  = 1'b0;
  logic         iRe  = 1'b0;
  logic [W-1:0] iWd  = '0;
  logic [W-1:0] oRd;
  logic         oFull;
  logic         oRvd;
  logic         oEmp;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] modelQ [$];
  logic [W-1:0] modelRd  = '0;
  logic         modelRvd = 1'b0;

  always #5 iCLK = ~iCLK;

  async_fifo_controller #(.pFifoDepth(DEPTH), .pFifoBitWidth(W)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .iWd  (iWd),
    .iWe  (iWe),
    .oFull(oFull),
    .iRe  (iRe),
    .oRd  (oRd),
    .oRvd (oRvd),
    .oEmp (oEmp)
  );

  // Reference: occupancy is the queue length; both requests judged against the pre-edge state.
  always @(posedge iCLK or posedge iRST) begin : refModel
    int occ;
    if (iRST) begin
      modelQ.delete();
      modelRd  <= '0;
      modelRvd <= 1'b0;
    end else begin
      occ = modelQ.size();
      modelRvd <= 1'b0;
      if (iRe && occ != 0) begin
        modelRd  <= modelQ.pop_front();
        modelRvd <= 1'b1;
      end
      if (iWe && occ != DEPTH) modelQ.push_back(iWd);
    end
  end

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("oEmp",  32'(oEmp),  32'(modelQ.size() == 0));
    checkValue("oFull", 32'(oFull), 32'(modelQ.size() == DEPTH));
    checkValue("oRvd",  32'(oRvd),  32'(modelRvd));
    checkValue("oRd",   32'(oRd),   32'(modelRd));
  endtask

  always @(negedge iCLK) checkOutput();

  task automatic applyStimulus(input logic we, input logic re, input logic [W-1:0] wd);
    @(negedge iCLK);
    iWe = we;
    iRe = re;
    iWd = wd;
  endtask

  initial begin : watchdog
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog timeout at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stimulus
    int wrVal;
    int rdExp;
    int readCount;
    logic [W-1:0] fillFirst;
    logic [W-1:0] wd;

    #1 iRST = 1'b1;
    repeat (5) @(negedge iCLK);
    checkValue("resetEmp",  32'(oEmp),  32'd1);
    checkValue("resetFull", 32'(oFull), 32'd0);
    checkValue("resetRvd",  32'(oRvd),  32'd0);
    checkValue("resetRd",   32'(oRd),   32'd0);
    iRST = 1'b0;

    applyStimulus(1'b1, 1'b0, 4'h5);
    applyStimulus(1'b0, 1'b1, 4'h0);
    checkValue("singleEmpFall", 32'(oEmp), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkValue("singleRvd", 32'(oRvd), 32'd1);
    checkValue("singleRd",  32'(oRd),  32'h5);
    checkValue("singleEmp", 32'(oEmp), 32'd1);

    // Streaming counter: the valid-qualified read data must be the same counter sequence.
    wrVal = 0;
    rdExp = 0;
    for (int cyc = 0; cyc < 230; cyc++) begin
      @(negedge iCLK);
      if (oRvd) begin
        checkValue("streamOrder", 32'(oRd), 32'(rdExp[3:0]));
        rdExp++;
      end
      if (cyc < 80) begin
        iWe = !oFull;
        iWd = wrVal[3:0];
        if (!oFull) wrVal++;
        iRe = !oEmp && ($urandom_range(0, 3) != 0);
      end else begin
        iWe = 1'b0;
        iRe = 1'b1;
      end
    end
    checkValue("streamCount", 32'(rdExp), 32'(wrVal));

    applyStimulus(1'b0, 1'b0, 4'h0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      wd = 4'($urandom);
      if (i == 0) fillFirst = wd;
      applyStimulus(1'b1, 1'b0, wd);
    end
    checkValue("fillFull", 32'(oFull), 32'd1);
    applyStimulus(1'b1, 1'b1, 4'h3);
    checkValue("overflowHeld", 32'(oFull), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkValue("fullBothRvd",  32'(oRvd),  32'd1);
    checkValue("fullBothRd",   32'(oRd),   32'(fillFirst));
    checkValue("fullBothFull", 32'(oFull), 32'd0);
    readCount = 1;
    for (int k = 0; k < DEPTH + 60; k++) begin
      applyStimulus(1'b0, 1'b1, 4'h0);
      if (oRvd) readCount++;
    end
    checkValue("drainCount", 32'(readCount), 32'd1024);
    checkValue("drainEmp",   32'(oEmp),      32'd1);

    applyStimulus(1'b1, 1'b1, 4'h9);
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkValue("emptyBothRvd", 32'(oRvd), 32'd0);
    checkValue("emptyBothEmp", 32'(oEmp), 32'd0);
    applyStimulus(1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkValue("emptyBothRd",  32'(oRd),  32'h9);
    checkValue("emptyBothEmp2", 32'(oEmp), 32'd1);

    // Random traffic, alternating write-heavy and read-heavy phases.
    for (int c = 0; c < 3000; c++) begin
      if ((c / 400) % 2 == 0)
        applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35, 4'($urandom));
      else
        applyStimulus($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70, 4'($urandom));
    end

    applyStimulus(1'b0, 1'b1, 4'h0);
    repeat (DEPTH + 10) applyStimulus(1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b0, 4'($urandom));
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkValue("preResetEmp", 32'(oEmp), 32'd0);
    #2 iRST = 1'b1;
    #1;
    checkValue("midResetEmp",  32'(oEmp),  32'd1);
    checkValue("midResetFull", 32'(oFull), 32'd0);
    checkValue("midResetRvd",  32'(oRvd),  32'd0);
    checkValue("midResetRd",   32'(oRd),   32'd0);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'hA);
    applyStimulus(1'b1, 1'b0, 4'hB);
    applyStimulus(1'b1, 1'b1, 4'hC);
    applyStimulus(1'b0, 1'b1, 4'h0);
    checkValue("postResetFirst", 32'(oRd), 32'hA);
    repeat (4) applyStimulus(1'b0, 1'b1, 4'h0);
    checkValue("postResetEmp", 32'(oEmp), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
